// File: rtl/vmicro16_uart_rx_apb.sv
// APB slave UART receiver: deserialises 8N1 frames from rx_wire into a byte FIFO
// that cores pop through the DATA register; STATUS exposes fill level and sticky errors.
module vmicro16_uart_rx_apb #(
  parameter int unsigned BUS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_WIDTH-1:0]  S_PADDR,
  input  logic                  S_PWRITE,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic [DATA_WIDTH-1:0] S_PWDATA,
  output logic [DATA_WIDTH-1:0] S_PRDATA,
  output logic                  S_PREADY,
  input  logic                  rx_wire,
  output logic                  rx_irq
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned TW           = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW           = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWait} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            sync_q, rx_s;
  logic            push_req, ferr_set;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW:0]     wptr_q, rptr_q, count;
  logic            full, empty, push, pop, ovr_set;
  logic            ovr_q, ferr_q, irq_q;
  logic            access, rd_data, wr_status;
  logic            unused_bits;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= rx_wire;
      rx_s   <= sync_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          timer_d = '0;
        end
      end
      StStart: begin
        // Mid-start-bit check: a line that is high again was only a glitch.
        if (timer_q == TW'(HALF_BIT - 1)) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? StIdle : StData;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StData: begin
        if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
          timer_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d = StStop;
          else bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StStop: begin
        if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
          timer_d = '0;
          if (rx_s) begin
            push_req = 1'b1;
            state_d  = StIdle;
          end else begin
            ferr_set = 1'b1;
            state_d  = StWait;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWait: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign count     = wptr_q - rptr_q;
  assign full      = (count == (AW + 1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign access    = S_PSELx & S_PENABLE;
  assign rd_data   = access & ~S_PWRITE & (S_PADDR[1:0] == 2'd0);
  assign wr_status = access & S_PWRITE & (S_PADDR[1:0] == 2'd1);
  assign pop       = rd_data & ~empty;
  // A same-cycle pop frees the slot the push needs.
  assign push      = push_req & (~full | pop);
  assign ovr_set   = push_req & full & ~pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      ovr_q  <= ovr_set | (ovr_q & ~(wr_status & S_PWDATA[2]));
      ferr_q <= ferr_set | (ferr_q & ~(wr_status & S_PWDATA[3]));
      irq_q  <= ~empty;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= shift_q;
  end

  always_comb begin
    S_PRDATA = '0;
    if (access && !S_PWRITE) begin
      unique case (S_PADDR[1:0])
        2'd0:    if (!empty) S_PRDATA[7:0] = mem_q[rptr_q[AW-1:0]];
        2'd1:    S_PRDATA[3:0] = {ferr_q, ovr_q, full, ~empty};
        default: S_PRDATA = '0;
      endcase
    end
  end

  assign S_PREADY    = access;
  assign rx_irq      = irq_q;
  assign unused_bits = ^{S_PADDR[BUS_WIDTH-1:2], S_PWDATA[DATA_WIDTH-1:4], S_PWDATA[1:0]};

endmodule
